minterm_lister: RTL and testbench
=================================

MINTERM_LISTER -- requirements
Module: minterm_lister

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, the number of function inputs; the truth table is 2**N_IN bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the request to scan; sampled only in IDLE.
REQ-005 The block SHALL have port tt, input, 2**N_IN, the truth table; bit i is the function output for input vector i, where a is the MSB and d is the LSB for N_IN=4.
REQ-006 The block SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-007 The block SHALL have port m_valid, output, 1, which marks a minterm index presented on m_index.
REQ-008 The block SHALL have port m_ready, input, 1, the consumer's acceptance of the presented minterm.
REQ-009 The block SHALL have port m_index, output, N_IN, the input vector whose table bit is 1.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse that marks the end of a scan.
REQ-011 The block SHALL have port count, output, N_IN+1, the number of minterms accepted in the last scan (0..2**N_IN).

Function
REQ-012 The block SHALL implement four states: IDLE, SCAN, EMIT and DONE.
REQ-013 In IDLE, on a clock edge with start=1, the block SHALL latch tt into an internal copy, set idx=0 and count=0, and go to SCAN.
REQ-014 The block SHALL use only the latched table for the whole scan; changes on tt while busy=1 SHALL have no effect.
REQ-015 In SCAN, the block SHALL examine one table bit per cycle, at position idx.
REQ-016 In SCAN with bit 0: if idx=2**N_IN-1, the block SHALL go to DONE; otherwise it SHALL increment idx and stay in SCAN.
REQ-017 In SCAN with bit 1, the block SHALL go to EMIT with m_index=idx and m_valid=1 from the next cycle.
REQ-018 In EMIT, m_valid and m_index SHALL stay stable until a clock edge with m_ready=1.
REQ-019 On the EMIT handshake edge, the block SHALL increment count; if idx=2**N_IN-1 it SHALL go to DONE, otherwise it SHALL increment idx and go to SCAN.
REQ-020 m_valid SHALL be 0 in IDLE, SCAN and DONE.
REQ-021 m_ready SHALL be ignored outside EMIT.
REQ-022 Minterms SHALL be emitted in strictly ascending index order, with no repeats and none skipped.
REQ-023 In DONE, the block SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-024 count SHALL hold its final value in IDLE until the next accepted start.
REQ-025 idx SHALL never wrap: the end condition is idx=2**N_IN-1 and is tested before any increment.
REQ-026 Latency: with start accepted at edge k and an all-zero table, done SHALL be high during the cycle after edge k+16 (N_IN=4).
REQ-027 Latency: if tt[0]=1, m_valid SHALL be high after edge k+1.
REQ-028 A start that is high while busy=1 (including in DONE) SHALL be ignored and not queued.
REQ-029 An all-ones table SHALL produce 16 handshakes and count=16; count width SHALL prevent overflow.

Reset
REQ-030 While rst=1, the block SHALL immediately force state=IDLE, idx=0, count=0, busy=0, m_valid=0, m_index=0 and done=0, independent of clk.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a done pulse; the first start after rst deasserts SHALL begin a fresh scan.

Verification
REQ-032 The bench SHALL cover: tt=16'h212F, start pulse, m_ready=1 held -> m_index 0,1,2,3,5,8,13 in order; then done pulse; then count=7.
REQ-033 The bench SHALL cover: tt=16'h0000, start -> no m_valid; done high 16 cycles after start is accepted; count=0.
REQ-034 The bench SHALL cover: tt=16'hFFFF, m_ready toggling every other cycle -> 16 handshakes with indices 0..15; m_index stable while stalled; count=16.
REQ-035 The bench SHALL cover: tt=16'h8000 with tt changed to 16'h0001 after start -> single emission m_index=15; count=1.
REQ-036 The bench SHALL cover: start re-pulsed while busy -> no restart, no second scan, and exactly one done.
REQ-037 The bench SHALL cover: rst asserted during EMIT of index 5 of 16'h212F -> outputs at reset values immediately; no done pulse; a new start gives the full 7-minterm sequence.

Source files
------------

// File: rtl/minterm_lister.sv
// minterm_lister: scans a latched truth table and lists the indices of its
// minterms, in ascending order, over a valid/ready handshake. It pulses done
// at the end of each scan and reports how many minterms were accepted.
module minterm_lister #(
   parameter int N_IN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [(1<<N_IN)-1:0]    tt,
   output logic                    busy,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [N_IN-1:0]         m_index,
   output logic                    done,
   output logic [N_IN:0]           count
);

   localparam logic [N_IN-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [N_IN-1:0]        idx;
   logic [(1<<N_IN)-1:0]   tt_q;

   // Scan FSM; every output is registered. The last index is tested before
   // any increment, so idx never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         count   <= '0;
         busy    <= 1'b0;
         m_valid <= 1'b0;
         m_index <= '0;
         done    <= 1'b0;
         tt_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tt_q  <= tt;
                  idx   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (tt_q[idx]) begin
                  m_index <= idx;
                  m_valid <= 1'b1;
                  state   <= EMIT;
               end else if (idx == LAST_IDX) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            EMIT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  count   <= count + 1'b1;
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SCAN;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_minterm_lister.sv
// tb_minterm_lister: directed scans of known truth tables with hand-computed
// minterm lists, latencies, counts and reset behaviour.
module tb_minterm_lister;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] tt;
   logic        busy;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_index;
   logic        done;
   logic [4:0]  count;

   int n_cmp;
   int n_err;

   // scan results recorded by run_scan
   logic [3:0] hs_idx [0:16];
   int         n_hs;
   int         done_cnt;
   int         done_cycle;
   int         first_valid;

   minterm_lister #(.N_IN(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tt      (tt),
      .busy    (busy),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_index (m_index),
      .done    (done),
      .count   (count)
   );

   // free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode bit0: m_ready toggles; bit1: re-pulse start while busy and in DONE
   task automatic run_scan(input logic [15:0] tbl, input logic [15:0] tt_after, input int mode);
      int  c;
      logic rdy;
      logic stalled;
      logic [3:0] stall_idx;
      int  extra_done, extra_valid, extra_busy;
      @(negedge clk);
      tt    = tbl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tt    = tt_after;
      check("busy_after_start", busy, 1);
      c = 0; n_hs = 0; done_cnt = 0; done_cycle = -1; first_valid = -1;
      stalled = 1'b0; stall_idx = '0;
      while (c < 200 && !(done_cnt > 0 && !busy)) begin
         if (stalled) begin
            check("stall_valid", m_valid, 1);
            check("stall_index", m_index, stall_idx);
         end
         if (m_valid && first_valid < 0) first_valid = c;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = c;
         end
         rdy = ((mode & 1) != 0) ? (c % 2 == 1) : 1'b1;
         m_ready = rdy;
         if (m_valid && rdy) begin
            if (n_hs < 17) hs_idx[n_hs] = m_index;
            n_hs++;
         end
         stalled   = m_valid && !rdy;
         stall_idx = m_index;
         if ((mode & 2) != 0) start = (c == 3 || c == 4 || done);
         @(negedge clk);
         c++;
      end
      start   = 1'b0;
      m_ready = 1'b0;
      check("scan_ended", busy, 0);
      check("done_pulses", done_cnt, 1);
      extra_done = 0; extra_valid = 0; extra_busy = 0;
      for (int i = 0; i < 20; i++) begin
         m_ready = 1'b1;
         if (done) extra_done++;
         if (m_valid) extra_valid++;
         if (busy) extra_busy++;
         @(negedge clk);
      end
      m_ready = 1'b0;
      check("idle_no_done", extra_done, 0);
      check("idle_no_valid", extra_valid, 0);
      check("idle_no_busy", extra_busy, 0);
   endtask

   task automatic check_212f(input string tag);
      logic [3:0] exp_list [0:6];
      exp_list = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
      check({tag, "_n_hs"}, n_hs, 7);
      for (int i = 0; i < 7; i++) check({tag, "_idx"}, hs_idx[i], exp_list[i]);
      check({tag, "_count"}, count, 7);
   endtask

   initial begin
      int c;
      int early_done;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; start = 1'b0; tt = '0; m_ready = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", m_valid, 0);
      check("rst_index", m_index, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 212F, ready held high
      run_scan(16'h212F, 16'h212F, 0);
      check_212f("t212f");
      check("t212f_first_valid", first_valid, 1);
      check("t212f_count_held", count, 7);

      // all-zero table: no emissions, done 16 cycles after start edge
      run_scan(16'h0000, 16'h0000, 0);
      check("t0000_n_hs", n_hs, 0);
      check("t0000_no_valid", first_valid, 32'hFFFF_FFFF);
      check("t0000_done_cycle", done_cycle, 16);
      check("t0000_count", count, 0);

      // all-ones table with toggling ready
      run_scan(16'hFFFF, 16'hFFFF, 1);
      check("tffff_n_hs", n_hs, 16);
      for (int i = 0; i < 16; i++) check("tffff_idx", hs_idx[i], i);
      check("tffff_count", count, 16);

      // table changed after start must not matter
      run_scan(16'h8000, 16'h0001, 0);
      check("t8000_n_hs", n_hs, 1);
      check("t8000_idx", hs_idx[0], 15);
      check("t8000_first_valid", first_valid, 16);
      check("t8000_count", count, 1);

      // start re-pulsed while busy and during DONE
      run_scan(16'h212F, 16'h212F, 2);
      check_212f("trepulse");

      // reset during EMIT of index 5
      @(negedge clk);
      tt = 16'h212F; start = 1'b1;
      @(negedge clk);
      start = 1'b0; m_ready = 1'b1;
      c = 0; early_done = 0;
      while (c < 50 && !(m_valid && m_index == 4'd5)) begin
         if (done) early_done++;
         @(negedge clk);
         c++;
      end
      check("abort_reached_idx5", m_index, 5);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", m_valid, 0);
      check("abort_index", m_index, 0);
      check("abort_done", done, 0);
      check("abort_count", count, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done) early_done++;
      end
      rst = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || busy) early_done++;
      end
      check("abort_no_done", early_done, 0);
      run_scan(16'h212F, 16'h212F, 0);
      check_212f("tafter_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
